ma_dcache: RTL

Word-granular, direct-mapped, write-through / no-write-allocate data cache. It is the responder on the memory-access interface driven by the MA pipeline stage. It answers loads and stores from the stage, asserts miss to stall the pipeline, and talks to backing data memory over a req/ack handshake. It sits between the MA stage and the data-memory model / bus.

---
 rtl/ma_dcache.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ma_dcache.sv
// Direct-mapped, word-granular, write-through / no-write-allocate data cache
// serving the MA stage, with a req/ack port to backing data memory.
module ma_dcache #(
   parameter int WIDTH    = 32,
   parameter int IDX_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       i_ma_MA,
   input  logic [WIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_inv,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_miss,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [WIDTH-1:0] o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wdata,
   input  logic             i_mem_ack,
   input  logic [WIDTH-1:0] i_mem_rdata
);

   localparam int TAG_BITS = WIDTH - 2 - IDX_BITS;
   localparam int NLINES   = 2 ** IDX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FILL  = 2'b01,
      S_WRITE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [NLINES-1:0]   r_valid;
   logic [TAG_BITS-1:0] r_tag  [NLINES];
   logic [WIDTH-1:0]    r_data [NLINES];

   logic [WIDTH-1:0]    r_dreg;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [WIDTH-1:0]    r_mem_addr;
   logic [WIDTH-1:0]    r_mem_wdata;
   logic                r_inv_pend;

   logic [IDX_BITS-1:0] w_idx;
   logic [TAG_BITS-1:0] w_tag;
   logic                w_hit;
   logic                w_is_load;
   logic                w_is_store;
   logic [IDX_BITS-1:0] w_m_idx;
   logic [TAG_BITS-1:0] w_m_tag;
   logic                w_m_hit;
   logic                w_ack_fill;
   logic                w_ack_write;
   logic                w_inv_apply;
   logic                w_unused;

   assign w_idx      = i_addr[IDX_BITS+1:2];
   assign w_tag      = i_addr[WIDTH-1:IDX_BITS+2];
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_is_load  = (i_ma_MA == 2'b01);
   assign w_is_store = (i_ma_MA == 2'b10);

   // Store-hit is judged at ack time against the captured address; lines cannot change mid-transaction.
   assign w_m_idx     = r_mem_addr[IDX_BITS+1:2];
   assign w_m_tag     = r_mem_addr[WIDTH-1:IDX_BITS+2];
   assign w_m_hit     = r_valid[w_m_idx] && (r_tag[w_m_idx] == w_m_tag);
   assign w_ack_fill  = (r_state == S_FILL) && i_mem_ack;
   assign w_ack_write = (r_state == S_WRITE) && i_mem_ack;
   assign w_inv_apply = ((r_state == S_IDLE) || (r_state == S_DONE)) && (i_inv || r_inv_pend);
   assign w_unused    = ^{i_addr[1:0], r_mem_addr[1:0]};

   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, stall and load-data selection.
   always_comb begin
      w_next_state = r_state;
      o_miss       = 1'b0;
      o_rdata      = r_dreg;
      case (r_state)
         S_IDLE: begin
            if (w_is_load) begin
               if (w_hit) begin
                  o_rdata = r_data[w_idx];
               end else begin
                  o_miss       = 1'b1;
                  w_next_state = S_FILL;
               end
            end else if (w_is_store) begin
               o_miss       = 1'b1;
               w_next_state = S_WRITE;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FILL, S_WRITE: begin
            o_miss = 1'b1;
            if (i_mem_ack) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = r_state;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Backing-memory request registers and the fill data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {WIDTH{1'b0}};
         r_mem_wdata <= {WIDTH{1'b0}};
         r_dreg      <= {WIDTH{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((w_next_state == S_FILL) || (w_next_state == S_WRITE)) begin
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= (w_next_state == S_WRITE);
                  r_mem_addr <= {i_addr[WIDTH-1:2], 2'b00};
                  if (w_next_state == S_WRITE) begin
                     r_mem_wdata <= i_wdata;
                  end
               end
            end
            S_FILL: begin
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_dreg    <= i_mem_rdata;
               end
            end
            S_WRITE: begin
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_mem_req <= r_mem_req;
            end
         endcase
      end
   end

   // Valid bits and deferred invalidate; an invalidate seen mid-transaction lands on DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= {NLINES{1'b0}};
         r_inv_pend <= 1'b0;
      end else begin
         if (w_inv_apply) begin
            r_valid <= {NLINES{1'b0}};
         end else if (w_ack_fill) begin
            r_valid[w_m_idx] <= 1'b1;
         end
         if ((r_state == S_FILL) || (r_state == S_WRITE)) begin
            if (i_inv) begin
               r_inv_pend <= 1'b1;
            end
         end else begin
            r_inv_pend <= 1'b0;
         end
      end
   end

   // Tag and data storage; validity is tracked separately so these need no reset.
   always_ff @(posedge clk) begin
      if (w_ack_fill) begin
         r_tag[w_m_idx]  <= w_m_tag;
         r_data[w_m_idx] <= i_mem_rdata;
      end else if (w_ack_write && w_m_hit) begin
         r_data[w_m_idx] <= r_mem_wdata;
      end
   end

endmodule
